// File: rtl/pipe_reg.sv
// Pipeline register stage with flush. Latency 1. Backpressure: in_ready from ~out_valid|out_ready,
// or with PIPE_REG_SKID_EN a registered ~skid_valid backed by a second (skid) entry.
// Flush kills every entry; out_data then takes (in_data & KEEP_MASK) | (BUBBLE & ~KEEP_MASK).
module pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BUBBLE    = '0,
    parameter logic [WIDTH-1:0] KEEP_MASK = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] flush_data;
    logic             accept;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_d;

    assign flush_data = (in_data & KEEP_MASK) | (BUBBLE & ~KEEP_MASK);

`ifdef PIPE_REG_SKID_EN
    logic             skid_valid;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] skid_data_d;
    logic             in_ready_q;

    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q & ~flush;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

    always_comb begin
        out_valid_d  = out_valid;
        out_data_d   = out_data;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = flush_data;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE;
        end else if (out_valid && !out_ready) begin
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (skid_valid) begin
            // skid_valid implies out_valid, so this branch is a consume: promote the skid entry
            out_valid_d  = 1'b1;
            out_data_d   = skid_data;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= BUBBLE;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE;
            in_ready_q <= 1'b0;
        end else begin
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            in_ready_q <= ~skid_valid_d;
        end
    end
`else
    logic consume;

    // Held low while reset is asserted so upstream never sees a ready stage in reset
    assign in_ready  = reset & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign consume   = out_valid & out_ready;
    assign occupancy = {1'b0, out_valid};

    always_comb begin
        out_valid_d = out_valid;
        out_data_d  = out_data;
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = flush_data;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= BUBBLE;
        end else begin
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: queue-based reference model checked every cycle plus directed literal vectors.
module tb_pipe_reg;

    localparam logic [31:0] BUB  = 32'h0000_0000;
    localparam logic [31:0] KEEP = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_errors = 0;

    pipe_reg #(.WIDTH(32), .BUBBLE(BUB), .KEEP_MASK(KEEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

`ifdef PIPE_REG_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    // Reference model: ordered queue of held payloads plus the last value shown on out_data
    logic [31:0] mq[$];
    logic [31:0] m_data = BUB;
    bit          m_rdy_reg = 1'b0;
    int          n_delivered = 0;

    function automatic bit m_in_ready();
        if (CAP == 2) return m_rdy_reg;
        return (mq.size() == 0) || out_ready;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_data    = BUB;
            m_rdy_reg = 1'b0;
        end else begin
            bit acc, con;
            acc = in_valid && m_in_ready() && !flush;
            con = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
                m_data = (in_data & KEEP) | (BUB & ~KEEP);
            end else begin
                if (con) begin
                    void'(mq.pop_front());
                    n_delivered++;
                end
                if (acc) mq.push_back(in_data);
                if (mq.size() > 0) m_data = mq[0];
            end
            m_rdy_reg = (mq.size() < 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("model_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
            chk("model_occupancy", {30'b0, occupancy}, mq.size());
            chk("model_out_data", out_data, m_data);
            if (!flush) chk("model_in_ready", {31'b0, in_ready}, {31'b0, m_in_ready()});
        end else begin
            chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
        end
    end

    task automatic step(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input bit v, input logic [31:0] d, input logic [1:0] occ);
        chk({name, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({name, "_data"}, out_data, d);
        chk({name, "_occ"}, {30'b0, occupancy}, {30'b0, occ});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, BUB, 2'd0);
        chk("reset_rdy", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
`ifdef PIPE_REG_SKID_EN
        chk("rel_rdy_before_edge", {31'b0, in_ready}, 32'd0);
`else
        chk("rel_rdy_comb", {31'b0, in_ready}, 32'd1);
`endif
        step(0, 0, 0, 0);
        chk("rel_rdy_after_edge", {31'b0, in_ready}, 32'd1);

        // streaming
        step(1, 32'h11, 1, 0); chk_out("s11", 1, 32'h11, 1);
        step(1, 32'h22, 1, 0); chk_out("s22", 1, 32'h22, 1);
        step(1, 32'h33, 1, 0); chk_out("s33", 1, 32'h33, 1);
        step(0, 32'h0, 1, 0);  chk_out("s_drain", 0, 32'h33, 0);

`ifdef PIPE_REG_SKID_EN
        step(1, 32'hA1, 0, 0); chk_out("bpA1", 1, 32'hA1, 1);
        chk("bpA1_rdy", {31'b0, in_ready}, 32'd1);
        step(1, 32'hA2, 0, 0); chk_out("bpA2", 1, 32'hA1, 2);
        chk("bpA2_rdy", {31'b0, in_ready}, 32'd0);
        step(0, 32'h0, 1, 0);  chk_out("bp_pop1", 1, 32'hA2, 1);
        chk("bp_pop1_rdy", {31'b0, in_ready}, 32'd1);
        step(0, 32'h0, 1, 0);  chk_out("bp_pop2", 0, 32'hA2, 0);
        step(1, 32'h1, 0, 0);
        step(1, 32'h2, 0, 0);  chk("fl_pre_occ", {30'b0, occupancy}, 32'd2);
`else
        step(1, 32'hB1, 0, 0); chk_out("bpB1", 1, 32'hB1, 1);
        chk("bpB1_rdy", {31'b0, in_ready}, 32'd0);
        step(1, 32'hB2, 0, 0); chk_out("bpB2_held", 1, 32'hB1, 1);
        step(1, 32'hB2, 1, 0); chk_out("bpB2_take", 1, 32'hB2, 1);
        step(0, 32'h0, 1, 0);  chk_out("bp_drain", 0, 32'hB2, 0);
        step(1, 32'h1, 0, 0);  chk("fl_pre_occ", {30'b0, occupancy}, 32'd1);
`endif
        // flush keeps the upper half of in_data, drops the payload
        step(1, 32'h1234_5678, 0, 1); chk_out("flush", 0, 32'h1234_0000, 0);
        step(0, 32'h0, 1, 0);         chk_out("post_flush1", 0, 32'h1234_0000, 0);
        step(0, 32'h0, 1, 0);         chk_out("post_flush2", 0, 32'h1234_0000, 0);

        // asynchronous reset in the middle of a cycle
        step(1, 32'h55, 0, 0); chk_out("pre_rst", 1, 32'h55, 1);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_out("async_rst", 0, BUB, 0);
        chk("async_rst_rdy", {31'b0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        step(0, 32'h0, 1, 0); chk_out("post_rst1", 0, BUB, 0);
        step(0, 32'h0, 1, 0); chk_out("post_rst2", 0, BUB, 0);

        // random traffic, model compare runs every cycle
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0);
        chk_out("final_empty", 0, out_data, 0);
        chk("delivered_any", {31'b0, n_delivered > 1000}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
